// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Shares one SRAM-like memory port between the instruction-fetch
//             requester (i_*) and the data requester (d_*). Grants at most
//             one request per cycle. Records which requester owns each
//             accepted, unanswered transaction, and uses that record to
//             route the in-order responses back to the right requester.
//  Config   : ARB_RR_EN - when defined, both requesters are arbitrated
//             round-robin. When undefined, data has fixed priority over
//             instruction fetch.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int MAX_OUTST = 4
) (
    input  logic        clk,
    input  logic        reset,
    // instruction-fetch requester
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_addr_ok,
    output logic        i_data_ok,
    // data requester
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [1:0]  d_size,
    input  logic [31:0] d_addr,
    input  logic [3:0]  d_wstrb,
    input  logic [31:0] d_wdata,
    output logic        d_addr_ok,
    output logic        d_data_ok,
    // shared response data
    output logic [31:0] rsp_rdata,
    // shared memory port
    output logic        m_req,
    output logic        m_wr,
    output logic [1:0]  m_size,
    output logic [31:0] m_addr,
    output logic [3:0]  m_wstrb,
    output logic [31:0] m_wdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok,
    input  logic [31:0] m_rdata,
    // diagnostics
    output logic        err_stray
);

    localparam int                 c_PTR_W    = $clog2(MAX_OUTST);
    localparam int                 c_CNT_W    = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(MAX_OUTST);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t               r_state;
    logic                 r_hold_d;      // side frozen while in HOLD (1 = data)
    logic [MAX_OUTST-1:0] r_fifo_is_d;   // owner of each outstanding slot (1 = data)
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;
    logic                 r_err_stray;

    logic w_full;
    logic w_sel_d;
    logic w_want;
    logic w_accept;
    logic w_pop;
    logic w_head_d;

`ifdef ARB_RR_EN
    logic r_rr_last_d;   // side granted at the most recent accept (1 = data)
`endif

    assign w_full = (r_count == c_CNT_FULL);

    // Pick the side to present: the frozen side while HOLD, otherwise arbitrate
    always_comb begin
        w_sel_d = 1'b0;
        w_want  = 1'b0;
        if (r_state == HOLD) begin
            w_sel_d = r_hold_d;
            w_want  = r_hold_d ? d_req : i_req;
        end else begin
            w_want  = d_req | i_req;
`ifdef ARB_RR_EN
            // On contention, the side not granted last time wins
            w_sel_d = d_req && (!i_req || !r_rr_last_d);
`else
            w_sel_d = d_req;
`endif
        end
    end

    // A full tracker blocks new requests even if a slot frees this cycle
    assign m_req     = w_want && !w_full;
    assign w_accept  = m_req && m_addr_ok;
    assign i_addr_ok = w_accept && !w_sel_d;
    assign d_addr_ok = w_accept && w_sel_d;

    // Fetches are always word reads, so their write-side fields are forced to zero
    assign m_addr  = w_sel_d ? d_addr  : i_addr;
    assign m_wr    = w_sel_d ? d_wr    : 1'b0;
    assign m_size  = w_sel_d ? d_size  : 2'd2;
    assign m_wstrb = w_sel_d ? d_wstrb : 4'h0;
    assign m_wdata = w_sel_d ? d_wdata : 32'h0;

    // Responses are in order, so the oldest tracked owner gets this response
    assign w_pop     = m_data_ok && (r_count != '0);
    assign w_head_d  = r_fifo_is_d[r_rd_ptr];
    assign i_data_ok = w_pop && !w_head_d;
    assign d_data_ok = w_pop && w_head_d;
    assign rsp_rdata = m_rdata;
    assign err_stray = r_err_stray;

    // Handshake FSM: freeze the presented side until the port accepts it
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_hold_d <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (m_req && !m_addr_ok) begin
                        r_state  <= HOLD;
                        r_hold_d <= w_sel_d;
                    end
                end
                HOLD: begin
                    if (w_accept) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Owner FIFO: push on accept, pop on response, count tracks occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fifo_is_d <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
        end else begin
            if (w_accept) begin
                r_fifo_is_d[r_wr_ptr] <= w_sel_d;
                r_wr_ptr              <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky flag for a response arriving with nothing outstanding
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_stray <= 1'b0;
        end else if (m_data_ok && (r_count == '0)) begin
            r_err_stray <= 1'b1;
        end
    end

`ifdef ARB_RR_EN
    // Remember which side was granted at every accept
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_last_d <= 1'b0;
        end else if (w_accept) begin
            r_rr_last_d <= w_sel_d;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_port_arbiter
//  Purpose  : Self-checking bench for mem_port_arbiter. Directed scenarios are
//             followed by a randomized phase. All of them are compared against
//             a transaction-level reference model (owner queue + lock state).
//  Config   : honours ARB_RR_EN in the same way as the design.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int MAX_OUTST = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, i_addr_ok, i_data_ok;
    logic [31:0] i_addr;
    logic        d_req, d_wr, d_addr_ok, d_data_ok;
    logic [1:0]  d_size;
    logic [31:0] d_addr, d_wdata;
    logic [3:0]  d_wstrb;
    logic [31:0] rsp_rdata;
    logic        m_req, m_wr;
    logic [1:0]  m_size;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_addr_ok, m_data_ok;
    logic [31:0] m_rdata;
    logic        err_stray;

    mem_port_arbiter #(.MAX_OUTST(MAX_OUTST)) dut (
        .clk       (clk),
        .reset     (reset),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_addr_ok (i_addr_ok),
        .i_data_ok (i_data_ok),
        .d_req     (d_req),
        .d_wr      (d_wr),
        .d_size    (d_size),
        .d_addr    (d_addr),
        .d_wstrb   (d_wstrb),
        .d_wdata   (d_wdata),
        .d_addr_ok (d_addr_ok),
        .d_data_ok (d_data_ok),
        .rsp_rdata (rsp_rdata),
        .m_req     (m_req),
        .m_wr      (m_wr),
        .m_size    (m_size),
        .m_addr    (m_addr),
        .m_wstrb   (m_wstrb),
        .m_wdata   (m_wdata),
        .m_addr_ok (m_addr_ok),
        .m_data_ok (m_data_ok),
        .m_rdata   (m_rdata),
        .err_stray (err_stray)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    bit mq[$];          // owners of outstanding transactions, oldest first (1 = data)
    bit lock_v;         // a request was shown and not yet accepted
    bit lock_d;         // side of that shown request
    bit m_err;          // expected sticky stray flag
`ifdef ARB_RR_EN
    bit rr_last_d;
`endif
    bit last_acc_i, last_acc_d;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        lock_v = 1'b0;
        lock_d = 1'b0;
        m_err  = 1'b0;
`ifdef ARB_RR_EN
        rr_last_d = 1'b0;
`endif
        last_acc_i = 1'b0;
        last_acc_d = 1'b0;
    endtask

    task automatic idle_inputs();
        i_req = 0; i_addr = 0;
        d_req = 0; d_wr = 0; d_size = 0; d_addr = 0; d_wstrb = 0; d_wdata = 0;
        m_addr_ok = 0; m_data_ok = 0; m_rdata = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
    endtask

    // One clock: predict from current inputs, compare, then advance the model
    task automatic cyc();
        bit full, sel_d, want, mreq, acc, pop, head;
        #2;
        full = (mq.size() == MAX_OUTST);
        if (lock_v) begin
            sel_d = lock_d;
            want  = lock_d ? d_req : i_req;
        end else begin
            want = d_req | i_req;
`ifdef ARB_RR_EN
            sel_d = d_req && (!i_req || !rr_last_d);
`else
            sel_d = d_req;
`endif
        end
        mreq = want && !full;
        acc  = mreq && m_addr_ok;
        pop  = m_data_ok && (mq.size() > 0);
        head = pop ? mq[0] : 1'b0;

        chk("m_req",     m_req,     mreq);
        chk("i_addr_ok", i_addr_ok, acc && !sel_d);
        chk("d_addr_ok", d_addr_ok, acc && sel_d);
        chk("i_data_ok", i_data_ok, pop && !head);
        chk("d_data_ok", d_data_ok, pop && head);
        chk("err_stray", err_stray, m_err);
        if (mreq) begin
            chk("m_addr",  m_addr,  sel_d ? d_addr : i_addr);
            chk("m_wr",    m_wr,    sel_d ? d_wr : 1'b0);
            chk("m_size",  m_size,  sel_d ? d_size : 2'd2);
            chk("m_wstrb", m_wstrb, sel_d ? d_wstrb : 4'h0);
            chk("m_wdata", m_wdata, sel_d ? d_wdata : 32'h0);
        end
        if (pop) chk("rsp_rdata", rsp_rdata, m_rdata);

        @(posedge clk);
        if (pop) void'(mq.pop_front());
        if (acc) mq.push_back(sel_d);
        if (m_data_ok && !pop) m_err = 1'b1;
        if (acc) begin
            lock_v = 1'b0;
`ifdef ARB_RR_EN
            rr_last_d = sel_d;
`endif
        end else if (mreq) begin
            lock_v = 1'b1;
            lock_d = sel_d;
        end
        last_acc_i = acc && !sel_d;
        last_acc_d = acc && sel_d;
        #1;
    endtask

    task automatic drain();
        i_req = 0; d_req = 0; m_addr_ok = 0;
        for (int k = 0; k < 4 * MAX_OUTST && mq.size() > 0; k++) begin
            m_data_ok = 1; m_rdata = $urandom;
            cyc();
        end
        m_data_ok = 0;
    endtask

    // New request fields only once the previous one is accepted or absent
    task automatic refresh_reqs();
        if (!i_req || last_acc_i) begin
            i_req  = ($urandom % 3) != 0;
            i_addr = $urandom;
        end
        if (!d_req || last_acc_d) begin
            d_req   = ($urandom % 3) == 0;
            d_wr    = $urandom;
            d_size  = 2'($urandom_range(0, 2));
            d_addr  = $urandom;
            d_wstrb = $urandom;
            d_wdata = $urandom;
        end
    endtask

    initial begin
        reset = 1'b1;
        do_reset();

        // Reset state with no activity
        cyc();

        // Single fetch, response three cycles after accept
        i_req = 1; i_addr = 32'h1c00_0000; m_addr_ok = 1;
        cyc();
        i_req = 0; m_addr_ok = 0;
        cyc();
        cyc();
        m_data_ok = 1; m_rdata = 32'h0280_0000;
        cyc();
        m_data_ok = 0;

        // Simultaneous requests: data first, then fetch, responses in order
        i_req = 1; i_addr = 32'h0000_0100;
        d_req = 1; d_wr = 1; d_size = 2; d_addr = 32'h0000_1000; d_wstrb = 4'hF; d_wdata = 32'hdead_beef;
        m_addr_ok = 1;
        cyc();
        if (last_acc_d) d_req = 0;
        cyc();
        i_req = 0; d_req = 0; m_addr_ok = 0;
        m_data_ok = 1; m_rdata = 32'h0000_0001;
        cyc();
        m_rdata = 32'h1111_2222;
        cyc();
        m_data_ok = 0;

        // Stalled data request, fetch arrives later and must wait
        d_req = 1; d_wr = 0; d_size = 1; d_addr = 32'h0000_2002; d_wstrb = 4'h3; d_wdata = 0;
        m_addr_ok = 0;
        cyc(); cyc(); cyc();
        i_req = 1; i_addr = 32'h0000_0200;
        cyc();
        m_addr_ok = 1;
        cyc();
        d_req = 0;
        cyc();
        i_req = 0;
        drain();

        // Stalled fetch, data arrives later: the frozen side stays on fetch
        i_req = 1; i_addr = 32'h0000_0300; m_addr_ok = 0;
        cyc();
        d_req = 1; d_wr = 1; d_size = 0; d_addr = 32'h0000_3001; d_wstrb = 4'h2; d_wdata = 32'h0000_ab00;
        cyc();
        m_addr_ok = 1;
        cyc();
        i_req = 0;
        cyc();
        d_req = 0;
        drain();

        // Fill the tracker, then free one slot
        i_req = 1; m_addr_ok = 1;
        for (int k = 0; k < MAX_OUTST; k++) begin
            i_addr = 32'h0000_4000 + 32'(4 * k);
            cyc();
        end
        i_addr = 32'h0000_5000;
        cyc();
        m_data_ok = 1; m_rdata = 32'h5555_aaaa;
        cyc();
        m_data_ok = 0;
        cyc();
        i_req = 0;
        drain();

        // Stray response sets the sticky flag, reset clears it
        m_data_ok = 1; m_rdata = 32'h0bad_0bad;
        cyc();
        m_data_ok = 0;
        cyc();
        do_reset();
        cyc();

        // Both sides continuously requesting for four accepts
        i_req = 1; i_addr = 32'h0000_6000;
        d_req = 1; d_wr = 0; d_size = 2; d_addr = 32'h0000_7000; d_wstrb = 0; d_wdata = 0;
        m_addr_ok = 1;
        for (int k = 0; k < 4; k++) begin
            cyc();
            if (last_acc_i) i_addr = i_addr + 32'd4;
            if (last_acc_d) d_addr = d_addr + 32'd4;
        end
        i_req = 0; d_req = 0;
        drain();

        // Randomized traffic with a reset in the middle
        for (int n = 0; n < 1500; n++) begin
            if (n == 750) begin
                do_reset();
            end
            refresh_reqs();
            m_addr_ok = ($urandom % 4) != 0;
            m_data_ok = (mq.size() > 0) ? (($urandom % 2) == 1) : (($urandom % 64) == 0);
            m_rdata   = $urandom;
            cyc();
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
